// File: rtl/target_centroid_tracker.sv
`timescale 1ns/1ps
// target_centroid_tracker
// Accumulates the coordinates of thresholded OV7670 pixels over one frame and
// computes their centroid with two sequential restoring dividers at frame end.
// The result feeds the HDMI overlay stage.
//
// Ports
//   s00_axi_aclk     in   sole clock (pixel stream is synchronous to it)
//   s00_axi_aresetn  in   asynchronous active-low reset
//   pix_valid        in   pixel qualifier
//   pix_x, pix_y     in   pixel column / row (10 bit)
//   pix_hit          in   thresholded mask bit, used only with pix_valid
//   frame_end        in   one-cycle pulse after the last pixel of a frame
//   target_x/_y      out  centroid column / row
//   target_found     out  last completed frame had >= MIN_COUNT hits
//   target_valid     out  one-cycle pulse when target_* update
//   busy             out  divider running
//   overrun          out  sticky: frame_end arrived while busy
//
// Optional build macro TARGET_SMOOTH_EN: when defined, consecutive found
// frames are averaged with the previous target instead of loaded directly.
//
// state  | meaning
// ACCUM  | accumulating pixels, waiting for frame_end
// DIV    | dividers running, SUM_W iterations
// DONE   | one cycle, target_valid asserted

module target_centroid_tracker #(
    parameter int IMG_W     = 640,
    parameter int IMG_H     = 480,
    parameter int MIN_COUNT = 64,
    parameter int CNT_W     = 19,
    parameter int SUM_W     = 28
) (
    input  logic       s00_axi_aclk,
    input  logic       s00_axi_aresetn,
    input  logic       pix_valid,
    input  logic [9:0] pix_x,
    input  logic [9:0] pix_y,
    input  logic       pix_hit,
    input  logic       frame_end,
    output logic [9:0] target_x,
    output logic [9:0] target_y,
    output logic       target_found,
    output logic       target_valid,
    output logic       busy,
    output logic       overrun
);

    localparam int ITER_W = $clog2(SUM_W);

    typedef enum logic [1:0] {S_ACCUM, S_DIV, S_DONE} state_t;

    state_t r_state, w_state_nx;

    logic [SUM_W-1:0]  r_sum_x, r_sum_y;
    logic [CNT_W-1:0]  r_count;
    logic [SUM_W-1:0]  r_dvd_x, r_dvd_y;
    logic [CNT_W-1:0]  r_rem_x, r_rem_y;
    logic [CNT_W-1:0]  r_div;
    logic [ITER_W-1:0] r_iter;
    logic [9:0]        r_tx, r_ty;
    logic              r_found, r_overrun;

    logic              w_hit;
    logic [SUM_W-1:0]  w_sx_tot, w_sy_tot;
    logic [CNT_W-1:0]  w_cnt_tot;
    logic              w_enough;
    logic [CNT_W-1:0]  w_sh_x, w_sh_y;
    logic              w_ge_x, w_ge_y;
    logic [CNT_W-1:0]  w_rem_x_nx, w_rem_y_nx;
    logic [9:0]        w_qx, w_qy;
    logic [9:0]        w_tx_new, w_ty_new;
    logic              w_div_last;

    assign w_hit = pix_valid && pix_hit
                   && ({22'b0, pix_x} < 32'(IMG_W))
                   && ({22'b0, pix_y} < 32'(IMG_H));

    // Totals include a hit arriving together with frame_end, so that pixel
    // lands in the ending frame's snapshot.
    assign w_sx_tot  = r_sum_x + (w_hit ? SUM_W'(pix_x) : '0);
    assign w_sy_tot  = r_sum_y + (w_hit ? SUM_W'(pix_y) : '0);
    assign w_cnt_tot = (w_hit && !(&r_count)) ? r_count + 1'b1 : r_count;
    assign w_enough  = (w_cnt_tot >= CNT_W'(MIN_COUNT));

    // Restoring step. The bit shifted out of the remainder MSB means the
    // shifted value already exceeds any CNT_W-bit divisor; the modular
    // subtraction then still yields the correct (smaller) remainder.
    assign w_sh_x     = {r_rem_x[CNT_W-2:0], r_dvd_x[SUM_W-1]};
    assign w_sh_y     = {r_rem_y[CNT_W-2:0], r_dvd_y[SUM_W-1]};
    assign w_ge_x     = r_rem_x[CNT_W-1] || (w_sh_x >= r_div);
    assign w_ge_y     = r_rem_y[CNT_W-1] || (w_sh_y >= r_div);
    assign w_rem_x_nx = w_ge_x ? (w_sh_x - r_div) : w_sh_x;
    assign w_rem_y_nx = w_ge_y ? (w_sh_y - r_div) : w_sh_y;

    // Final quotient bits, valid on the last iteration.
    assign w_qx = {r_dvd_x[8:0], w_ge_x};
    assign w_qy = {r_dvd_y[8:0], w_ge_y};

`ifdef TARGET_SMOOTH_EN
    assign w_tx_new = r_found ? 10'(({1'b0, r_tx} + {1'b0, w_qx}) >> 1) : w_qx;
    assign w_ty_new = r_found ? 10'(({1'b0, r_ty} + {1'b0, w_qy}) >> 1) : w_qy;
`else
    assign w_tx_new = w_qx;
    assign w_ty_new = w_qy;
`endif

    assign w_div_last = (r_state == S_DIV) && (r_iter == '0);

    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) r_state <= S_ACCUM;
        else                  r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            S_ACCUM: if (frame_end) w_state_nx = w_enough ? S_DIV : S_DONE;
            S_DIV:   if (r_iter == '0) w_state_nx = S_DONE;
            S_DONE:  w_state_nx = S_ACCUM;
            default: w_state_nx = S_ACCUM;
        endcase
    end

    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            r_sum_x   <= '0;
            r_sum_y   <= '0;
            r_count   <= '0;
            r_dvd_x   <= '0;
            r_dvd_y   <= '0;
            r_rem_x   <= '0;
            r_rem_y   <= '0;
            r_div     <= '0;
            r_iter    <= '0;
            r_tx      <= '0;
            r_ty      <= '0;
            r_found   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_sum_x <= frame_end ? '0 : w_sx_tot;
            r_sum_y <= frame_end ? '0 : w_sy_tot;
            r_count <= frame_end ? '0 : w_cnt_tot;

            if (r_state == S_ACCUM && frame_end && w_enough) begin
                r_dvd_x <= w_sx_tot;
                r_dvd_y <= w_sy_tot;
                r_div   <= w_cnt_tot;
                r_rem_x <= '0;
                r_rem_y <= '0;
                r_iter  <= ITER_W'(SUM_W - 1);
            end else if (r_state == S_DIV) begin
                r_dvd_x <= {r_dvd_x[SUM_W-2:0], w_ge_x};
                r_dvd_y <= {r_dvd_y[SUM_W-2:0], w_ge_y};
                r_rem_x <= w_rem_x_nx;
                r_rem_y <= w_rem_y_nx;
                r_iter  <= r_iter - 1'b1;
            end

            // Outputs are loaded on entry to DONE so target_valid (decoded
            // from the DONE state) coincides with the new values.
            if (r_state == S_ACCUM && frame_end && !w_enough) begin
                r_found <= 1'b0;
            end else if (w_div_last) begin
                r_found <= 1'b1;
                r_tx    <= w_tx_new;
                r_ty    <= w_ty_new;
            end

            if (r_state != S_ACCUM && frame_end) r_overrun <= 1'b1;
        end
    end

    assign target_x     = r_tx;
    assign target_y     = r_ty;
    assign target_found = r_found;
    assign target_valid = (r_state == S_DONE);
    assign busy         = (r_state == S_DIV);
    assign overrun      = r_overrun;

endmodule

// File: tb/tb_target_centroid_tracker.sv
`timescale 1ns/1ps
module tb_target_centroid_tracker;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       pix_valid = 1'b0;
    logic       pix_hit = 1'b0;
    logic       frame_end = 1'b0;
    logic [9:0] pix_x = '0;
    logic [9:0] pix_y = '0;
    logic [9:0] target_x, target_y;
    logic       target_found, target_valid, busy, overrun;

    target_centroid_tracker dut (
        .s00_axi_aclk    (clk),
        .s00_axi_aresetn (rst_n),
        .pix_valid       (pix_valid),
        .pix_x           (pix_x),
        .pix_y           (pix_y),
        .pix_hit         (pix_hit),
        .frame_end       (frame_end),
        .target_x        (target_x),
        .target_y        (target_y),
        .target_found    (target_found),
        .target_valid    (target_valid),
        .busy            (busy),
        .overrun         (overrun)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    int m_x = 0, m_y = 0, m_found = 0;
    int cap_x, cap_y, cap_found;
    int lat;
    bit saw_busy;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Expected target update for a completed frame.
    task automatic model(input int found, input int qx, input int qy);
        if (found != 0) begin
`ifdef TARGET_SMOOTH_EN
            if (m_found != 0) begin
                m_x = (m_x + qx) >> 1;
                m_y = (m_y + qy) >> 1;
            end else begin
                m_x = qx;
                m_y = qy;
            end
`else
            m_x = qx;
            m_y = qy;
`endif
        end
        m_found = found;
    endtask

    task automatic hits(input int n, input int x, input int y);
        for (int i = 0; i < n; i++) begin
            pix_valid = 1'b1;
            pix_hit   = 1'b1;
            pix_x     = 10'(x);
            pix_y     = 10'(y);
            @(posedge clk); #1;
        end
        pix_valid = 1'b0;
        pix_hit   = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic pulse_fe(input bit with_hit, input int x, input int y);
        pix_valid = with_hit;
        pix_hit   = with_hit;
        pix_x     = 10'(x);
        pix_y     = 10'(y);
        frame_end = 1'b1;
        @(posedge clk); #1;
        frame_end = 1'b0;
        pix_valid = 1'b0;
        pix_hit   = 1'b0;
    endtask

    // Waits for target_valid; lat is the cycle number counted from frame_end
    // (cycle 0), or -1 if none arrives within the budget.
    task automatic wait_valid(input int c0, input int budget, output int l, output bit sb);
        l  = -1;
        sb = 1'b0;
        for (int c = c0; c < c0 + budget; c++) begin
            @(negedge clk);
            if (busy) sb = 1'b1;
            if (target_valid) begin
                l         = c;
                cap_x     = int'(target_x);
                cap_y     = int'(target_y);
                cap_found = int'(target_found);
                @(posedge clk); #1;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic check_result(input string tag, input int exp_lat);
        check_eq({tag, "_lat"},   lat,       exp_lat);
        check_eq({tag, "_x"},     cap_x,     m_x);
        check_eq({tag, "_y"},     cap_y,     m_y);
        check_eq({tag, "_found"}, cap_found, m_found);
        @(negedge clk);
        check_eq({tag, "_pulse"}, target_valid, 0);
        @(posedge clk); #1;
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #20;
        check_eq("rst_x",       target_x,     0);
        check_eq("rst_y",       target_y,     0);
        check_eq("rst_found",   target_found, 0);
        check_eq("rst_valid",   target_valid, 0);
        check_eq("rst_busy",    busy,         0);
        check_eq("rst_overrun", overrun,      0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // Single-point target.
        hits(100, 200, 150);
        pulse_fe(0, 0, 0);
        wait_valid(1, 60, lat, saw_busy);
        model(1, 200, 150);
        check_result("f1", 29);
        check_eq("f1_busy", saw_busy, 1);

        // Two clusters: 12832/64 = 200, 9632/64 = 150 (truncated).
        hits(32, 100, 100);
        hits(32, 301, 201);
        pulse_fe(0, 0, 0);
        wait_valid(1, 60, lat, saw_busy);
        model(1, 200, 150);
        check_result("f2", 29);

        // Sums of 1 over 64 hits truncate to 0.
        hits(1, 0, 0);
        hits(1, 1, 0);
        hits(1, 0, 1);
        hits(61, 0, 0);
        pulse_fe(0, 0, 0);
        wait_valid(1, 60, lat, saw_busy);
        model(1, 0, 0);
        check_result("f3", 29);

        // 63 hits: below threshold, no division.
        hits(63, 5, 5);
        pulse_fe(0, 0, 0);
        wait_valid(1, 60, lat, saw_busy);
        model(0, 0, 0);
        check_result("f4", 1);
        check_eq("f4_nobusy", saw_busy, 0);

        // 63 hits plus one coincident with frame_end reaches 64.
        hits(63, 10, 10);
        pulse_fe(1, 10, 10);
        wait_valid(1, 60, lat, saw_busy);
        model(1, 10, 10);
        check_result("f5", 29);

        // Out-of-range and unqualified pixels must not contribute.
        hits(99, 10, 10);
        hits(5, 640, 10);
        hits(5, 10, 480);
        pix_valid = 1'b0; pix_hit = 1'b1; pix_x = 10'd500; pix_y = 10'd400;
        idle(3);
        pix_valid = 1'b1; pix_hit = 1'b0;
        idle(3);
        pix_valid = 1'b0;
        pix_hit   = 1'b0;
        pulse_fe(0, 0, 0);
        wait_valid(1, 60, lat, saw_busy);
        model(1, 10, 10);
        check_result("f6", 29);

        // frame_end during division: dropped frame, sticky overrun.
        hits(100, 200, 150);
        pulse_fe(0, 0, 0);
        hits(4, 600, 400);
        pulse_fe(0, 0, 0);
        wait_valid(6, 60, lat, saw_busy);
        model(1, 200, 150);
        check_result("f7", 29);
        check_eq("f7_overrun", overrun, 1);
        wait_valid(0, 50, lat, saw_busy);
        check_eq("f7_no_second", lat, -1);

        // Accumulators were cleared by the dropped frame_end.
        hits(100, 300, 250);
        pulse_fe(0, 0, 0);
        wait_valid(1, 60, lat, saw_busy);
        model(1, 300, 250);
        check_result("f8", 29);
        check_eq("f8_overrun", overrun, 1);

        // Reset mid-division abandons it.
        hits(100, 50, 60);
        pulse_fe(0, 0, 0);
        idle(10);
        rst_n = 1'b0;
        #2;
        check_eq("mrst_x",       target_x,     0);
        check_eq("mrst_y",       target_y,     0);
        check_eq("mrst_found",   target_found, 0);
        check_eq("mrst_valid",   target_valid, 0);
        check_eq("mrst_busy",    busy,         0);
        check_eq("mrst_overrun", overrun,      0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        wait_valid(0, 40, lat, saw_busy);
        check_eq("mrst_no_pulse", lat, -1);
        check_eq("mrst_no_busy",  saw_busy, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/target_centroid_tracker.md
Name: target_centroid_tracker

Overview:
- Consumes the binarized OV7670 pixel stream: pixel coordinates plus a per-pixel threshold hit.
- Accumulates the coordinate sums and the hit count of all hit pixels over one frame, then divides sequentially at frame end.
- Produces the target_x/target_y pair consumed by the OV7670/HDMI overlay stage, plus a found flag and a one-cycle update strobe.

Parameters:
- IMG_W, 640, active pixels per line; pixels with pix_x >= IMG_W are ignored.
- IMG_H, 480, active lines per frame; pixels with pix_y >= IMG_H are ignored.
- MIN_COUNT, 64, minimum hit count per frame for a valid target.
- CNT_W, 19, hit counter width; must hold IMG_W*IMG_H.
- SUM_W, 28, coordinate-sum accumulator width; must hold (IMG_W-1)*IMG_W*IMG_H.

Ports:
- s00_axi_aclk  input  1  sole clock; the pixel stream is already synchronous to it.
- s00_axi_aresetn  input  1  asynchronous active-low reset.
- pix_valid  input  1  pixel qualifier.
- pix_x  input  10  pixel column.
- pix_y  input  10  pixel row.
- pix_hit  input  1  thresholded mask bit; only meaningful when pix_valid=1.
- frame_end  input  1  one-cycle pulse after the last pixel of a frame.
- target_x  output  10  centroid column.
- target_y  output  10  centroid row.
- target_found  output  1  last completed frame had count >= MIN_COUNT.
- target_valid  output  1  one-cycle pulse when target_* update.
- busy  output  1  divider running.
- overrun  output  1  sticky; a frame_end arrived while busy.

Behaviour:
- Clock and reset: one clock, s00_axi_aclk. Reset s00_axi_aresetn is asynchronous, active-low.
- Reset values: target_x=0, target_y=0, target_found=0, target_valid=0, busy=0, overrun=0. Accumulators, divider registers and FSM return to ACCUM. Reset mid-division abandons the division and produces no target_valid.
- Accumulation (all states):
  - When pix_valid and pix_hit are both 1 and the pixel is in range: sum_x += pix_x, sum_y += pix_y, count += 1.
  - Widths are zero-extended; there is no overflow within the parameter bounds.
  - count saturates at all-ones as a guard.
- frame_end in the same cycle as a hit pixel: that pixel belongs to the ending frame. It is included in the snapshot, and the new-frame accumulators start from 0.
- FSM states: ACCUM, DIV, DONE.
  - ACCUM, frame_end=1, count_total >= MIN_COUNT:
    - Snapshot sum_x, sum_y and count, including any coincident pixel.
    - Clear the accumulators.
    - Go to DIV and set busy=1.
  - ACCUM, frame_end=1, count_total < MIN_COUNT:
    - Clear the accumulators and go to DONE with found_next=0.
    - Divider not started; target_x/target_y hold their previous values.
  - DIV:
    - Two parallel restoring dividers, sum_x/count and sum_y/count, unsigned, 1 quotient bit per cycle, SUM_W iterations.
    - The low 10 quotient bits are the result; the quotient is always < IMG_W or < IMG_H respectively.
    - After the last iteration go to DONE.
  - DONE (one cycle):
    - Register the outputs, target_found=found_next, target_valid=1, busy=0.
    - Return to ACCUM.
- Latency: frame_end at cycle 0.
  - Divide path: target_valid at cycle SUM_W+1 (29 with defaults).
  - Below-threshold path: target_valid at cycle 1.
- frame_end while in DIV or DONE:
  - The snapshot for that frame is discarded, overrun is set (sticky until reset), and the accumulators are still cleared.
  - The running division is unaffected.
- pix_valid=0 cycles: no accumulation. pix_hit is ignored when pix_valid=0.
- Accumulation is never stalled; the block has no backpressure.

Optional Feature:
- Macro TARGET_SMOOTH_EN.
- Defined:
  - In DONE with found_next=1 and target_found currently 1: target_x=(target_x+qx)>>1 and likewise for y, using 11-bit intermediates with truncation.
  - If target_found is currently 0, the quotient loads directly.
- Undefined: the quotient loads directly every frame. Latency is identical either way.

Test Plan:
- Reset, then a frame where 100 hit pixels all lie at (200,150), then frame_end -> target_valid exactly 29 cycles later; target_x=200, target_y=150, target_found=1.
- Frame of 64 hits: 32 at (100,100) and 32 at (301,201) -> target_x=200, target_y=150. The truncation check with 301 is covered by a frame with hits at (0,0),(1,0),(0,1) padded to 64 hits at (0,0) -> target_x=0, target_y=0.
- Frame with 63 hits -> target_valid at cycle 1; target_found=0; target_x/target_y unchanged from the previous frame; busy never asserts.
- A hit pixel at (10,10) coincident with frame_end, plus 99 hits at (10,10) in the next frame -> first frame count is 1 more; the second frame result is (10,10) with count 99. Pixels at x=640 or y=480 are ignored.
- frame_end issued 5 cycles after a division starts -> overrun=1 (sticky); the first result is still delivered correctly; no second target_valid for the dropped frame. Assert reset mid-division -> all outputs 0 and no pulse.
- With TARGET_SMOOTH_EN: frame at (200,150) then frame at (300,250) -> second output is (250,200). Without the macro -> (300,250).
